// File: rtl/sr_pkg.sv
// Shared definitions for the 2x line doubler: FSM states, default sizes, counter widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sr_pkg;

    localparam int DEF_WIDTH       = 320;
    localparam int DEF_HEIGHT      = 240;
    localparam int DEF_PIXEL_WIDTH = 24;

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit counter.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Write column / line-buffer address width.
    function automatic int col_w(input int width);
        return clog2_min1(width);
    endfunction

    // Output column width; always one bit wider than the source column so that
    // out_col>>1 is exactly a line-buffer address.
    function automatic int ocol_w(input int width);
        return col_w(width) + 1;
    endfunction

    // Source row width.
    function automatic int row_w(input int height);
        return clog2_min1(height);
    endfunction

    localparam int COL_W  = col_w(DEF_WIDTH);
    localparam int OCOL_W = ocol_w(DEF_WIDTH);
    localparam int ROW_W  = row_w(DEF_HEIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sr_line_ram.sv
// One-line pixel buffer: independent write port and registered read port.
// Latency: read data appears the cycle after re is sampled; write is visible to reads on the next cycle.
// Backpressure: none; caller only issues reads it has room to hold.
//
// Ports:
//   clk           clock
//   we/waddr/wdata write strobe, address, data
//   re/raddr      read strobe and address
//   rdata         registered read data (held while re is low)
module sr_line_ram
    import sr_pkg::*;
#(
    parameter int DEPTH  = DEF_WIDTH,
    parameter int DATA_W = DEF_PIXEL_WIDTH,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sr_line_doubler.sv
// 2x nearest-neighbour upscaler: buffers one source line from the upstream FIFO, then streams it twice with each pixel doubled.
// Latency: first output beat of a line 2 cycles after the last line-buffer write; 1 beat/cycle in FILL and EMIT.
// Backpressure: m_ready low holds the output beat stable indefinitely; FIFO starvation stalls FILL without advancing.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fifo_count          upstream FIFO fill count (lags reads by one cycle)
//   fifo_data           upstream FIFO data, valid the cycle after fifo_rd
//   fifo_rd             FIFO read strobe
//   m_data/m_valid      upscaled pixel stream, accepted when m_ready is high
//   m_sof/m_eol         first pixel of frame / last pixel of each output line
//   frame_done          one-cycle pulse after the final pixel of a frame is accepted
//   busy                high outside IDLE
module sr_line_doubler
    import sr_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    input  logic [PIXEL_WIDTH-1:0] fifo_data,
    output logic                   fifo_rd,
    output logic [PIXEL_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int CW  = col_w(WIDTH);
    localparam int OCW = ocol_w(WIDTH);
    localparam int RW  = row_w(HEIGHT);
    localparam int NW  = clog2_min1(WIDTH + 1);

    localparam logic [CW-1:0]          COL_LAST  = CW'(WIDTH - 1);
    localparam logic [OCW-1:0]         OCOL_LAST = OCW'(2 * WIDTH - 1);
    localparam logic [RW-1:0]          ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [NW-1:0]          RD_TOTAL  = NW'(WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    state_t state, state_nxt;

    // Fill side
    logic [NW-1:0] rd_issued;   // reads issued for the current line
    logic          rd_d1;       // fifo_rd last cycle == fifo_data valid now
    logic [CW-1:0] wr_col;
    logic          wr_last;

    // Acceptance side (what the downstream has actually taken)
    logic [OCW-1:0] out_col;
    logic           rep;
    logic [RW-1:0]  src_row;
    logic           beat_take;
    logic           last_beat;

    // Fetch side (what has been requested from the line RAM)
    logic [OCW-1:0] pf_col;
    logic           pf_rep;
    logic           pf_done;
    logic           issue;
    logic [1:0]     occ;

    // Read in flight (RAM output valid next cycle) and skid slot
    logic                   a_vld, a_sof, a_eol;
    logic                   s_vld, s_sof, s_eol;
    logic [PIXEL_WIDTH-1:0] s_data;
    logic [PIXEL_WIDTH-1:0] ram_rdata;

    sr_line_ram #(
        .DEPTH  (WIDTH),
        .DATA_W (PIXEL_WIDTH)
    ) u_line_ram (
        .clk   (clk),
        .we    (rd_d1),
        .waddr (wr_col),
        .wdata (fifo_data),
        .re    (issue),
        .raddr (pf_col[OCW-1:1]),
        .rdata (ram_rdata)
    );

    // The count lags a read by one cycle, so a count of 1 straight after a read
    // may already be stale; only trust it when no read was issued last cycle.
    always_comb begin
        fifo_rd = 1'b0;
        if (!rst && state == FILL && rd_issued < RD_TOTAL) begin
            if (fifo_count > CNT_ONE || (fifo_count == CNT_ONE && !rd_d1)) begin
                fifo_rd = 1'b1;
            end
        end
    end

    assign wr_last   = rd_d1 && (wr_col == COL_LAST);
    assign beat_take = m_valid && m_ready;
    assign last_beat = beat_take && (out_col == OCOL_LAST);

    // Beats held after this edge (in flight + output + skid, minus one leaving)
    // must stay at most 2, so a new read is only issued below that.
    assign occ   = ({1'b0, a_vld} + {1'b0, m_valid} + {1'b0, s_vld}) - {1'b0, beat_take};
    assign issue = (state == EMIT) && !pf_done && (occ < 2'd2);

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (wr_last) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (last_beat && rep) begin
                    state_nxt = (src_row == ROW_LAST) ? DONE : FILL;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill side: count reads, write captured data into the line buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_issued <= '0;
            rd_d1     <= 1'b0;
            wr_col    <= '0;
        end else begin
            rd_d1 <= fifo_rd;
            if (wr_last) begin
                rd_issued <= '0;
            end else if (fifo_rd) begin
                rd_issued <= rd_issued + 1'b1;
            end
            if (rd_d1) begin
                wr_col <= (wr_col == COL_LAST) ? '0 : wr_col + 1'b1;
            end
        end
    end

    // Fetch side: walks 2 reps x 2*WIDTH beats per line, tagging each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_col  <= '0;
            pf_rep  <= 1'b0;
            pf_done <= 1'b0;
            a_vld   <= 1'b0;
            a_sof   <= 1'b0;
            a_eol   <= 1'b0;
        end else begin
            a_vld <= issue;
            a_sof <= (src_row == '0) && !pf_rep && (pf_col == '0);
            a_eol <= (pf_col == OCOL_LAST);
            if (state == FILL && wr_last) begin
                pf_col  <= '0;
                pf_rep  <= 1'b0;
                pf_done <= 1'b0;
            end else if (issue) begin
                if (pf_col == OCOL_LAST) begin
                    pf_col <= '0;
                    if (pf_rep) begin
                        pf_done <= 1'b1;
                    end else begin
                        pf_rep <= 1'b1;
                    end
                end else begin
                    pf_col <= pf_col + 1'b1;
                end
            end
        end
    end

    // Output register plus skid: RAM data lands in the output register when it
    // is free (or being drained), otherwise in the skid slot. Order is kept
    // because the skid always drains into the output before the RAM does.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            s_vld   <= 1'b0;
            s_data  <= '0;
            s_sof   <= 1'b0;
            s_eol   <= 1'b0;
        end else if (beat_take) begin
            if (s_vld) begin
                m_data  <= s_data;
                m_sof   <= s_sof;
                m_eol   <= s_eol;
                m_valid <= 1'b1;
                s_vld   <= a_vld;
                if (a_vld) begin
                    s_data <= ram_rdata;
                    s_sof  <= a_sof;
                    s_eol  <= a_eol;
                end
            end else if (a_vld) begin
                m_data  <= ram_rdata;
                m_sof   <= a_sof;
                m_eol   <= a_eol;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
                m_sof   <= 1'b0;
                m_eol   <= 1'b0;
            end
        end else if (!m_valid) begin
            if (a_vld) begin
                m_data  <= ram_rdata;
                m_sof   <= a_sof;
                m_eol   <= a_eol;
                m_valid <= 1'b1;
            end
        end else if (a_vld) begin
            s_data <= ram_rdata;
            s_sof  <= a_sof;
            s_eol  <= a_eol;
            s_vld  <= 1'b1;
        end
    end

    // Acceptance side: counts beats actually taken; drives line/frame sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_col <= '0;
            rep     <= 1'b0;
            src_row <= '0;
        end else begin
            if (beat_take) begin
                if (out_col == OCOL_LAST) begin
                    out_col <= '0;
                    if (!rep) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        // Last row is held and cleared in DONE so it never wraps.
                        if (src_row != ROW_LAST) begin
                            src_row <= src_row + 1'b1;
                        end
                    end
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
            if (state == DONE) begin
                src_row <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sr_line_doubler.sv
module tb_sr_line_doubler;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int PW  = 24;
    localparam int CNW = 10;

    typedef struct {
        logic [PW-1:0] d;
        logic          sof;
        logic          eol;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [CNW-1:0] fifo_count;
    logic [PW-1:0]  fifo_data = '0;
    logic           fifo_rd;
    logic [PW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_sof;
    logic           m_eol;
    logic           frame_done;
    logic           busy;

    sr_line_doubler #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .PIXEL_WIDTH (PW),
        .COUNT_WIDTH (CNW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_count (fifo_count),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- upstream FIFO model ----------------
    logic [PW-1:0]  fq[$];
    logic [CNW-1:0] real_cnt = '0;
    bit             starve = 0;
    bit             gate = 0;
    int             gcnt = 0;

    // Count is the occupancy before this edge's pop: one cycle stale after a read.
    always @(posedge clk) begin
        int sz;
        sz = fq.size();
        if (fifo_rd && sz != 0) begin
            fifo_data <= fq.pop_front();
        end
        real_cnt <= CNW'(sz);
        if (gcnt == 2) begin
            gcnt = 0;
            gate <= ~gate;
        end else begin
            gcnt++;
        end
    end

    assign fifo_count = starve ? ((gate && real_cnt != '0) ? CNW'(1) : CNW'(0)) : real_cnt;

    // ---------------- downstream ready driver ----------------
    bit bp_mode = 0;
    always @(posedge clk) begin
        #1;
        m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- reference model / scoreboard ----------------
    beat_t exp_q[$];

    // Each source line yields two identical output lines, each pixel doubled.
    task automatic push_frame(input bit seq);
        logic [PW-1:0] line [W];
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                line[c] = seq ? PW'(r * W + c + 1) : PW'($urandom);
                fq.push_back(line[c]);
            end
            for (int rr = 0; rr < 2; rr++) begin
                for (int k = 0; k < 2 * W; k++) begin
                    beat_t b;
                    b.d    = line[k / 2];
                    b.sof  = (r == 0 && rr == 0 && k == 0);
                    b.eol  = (k == 2 * W - 1);
                    b.last = (r == H - 1 && rr == 1 && k == 2 * W - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    int            beats = 0, sofs = 0, eols = 0, rds = 0, done_seen = 0;
    bit            done_pending = 0;
    bit            prev_stall = 0;
    bit            rd_prev_s = 0;
    logic [PW-1:0] p_data;
    logic          p_sof, p_eol;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 0;
            done_pending = 0;
            rd_prev_s    = 0;
        end else begin
            if (frame_done || done_pending) begin
                chk("frame_done_timing", 32'(frame_done), 32'(done_pending));
                if (frame_done) done_seen++;
                done_pending = 0;
            end
            if (fifo_rd) begin
                rds++;
                chk("fifo_rd_underflow", 32'(fq.size() != 0), 32'd1);
                chk("fifo_rd_count_rule",
                    32'((fifo_count > CNW'(1)) || (fifo_count == CNW'(1) && !rd_prev_s)), 32'd1);
            end
            rd_prev_s = fifo_rd;
            if (prev_stall) begin
                chk("stall_hold", {5'd0, m_valid, m_sof, m_eol, m_data},
                    {5'd0, 1'b1, p_sof, p_eol, p_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", m_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {6'd0, m_sof, m_eol, m_data}, {6'd0, e.sof, e.eol, e.d});
                    if (e.last) done_pending = 1;
                end
                beats++;
                if (m_sof) sofs++;
                if (m_eol) eols++;
            end
            prev_stall = m_valid && !m_ready;
            p_data = m_data;
            p_sof  = m_sof;
            p_eol  = m_eol;
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic clear_stats();
        beats = 0;
        sofs  = 0;
        eols  = 0;
        rds   = 0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (done_seen < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_completed"}, 32'(done_seen >= target), 32'd1);
        chk({name, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_fifo_drained"}, 32'(fq.size()), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stats(input string name, input int frames);
        chk({name, "_beats"}, 32'(beats), 32'(frames * 4 * W * H));
        chk({name, "_sof"}, 32'(sofs), 32'(frames));
        chk({name, "_eol"}, 32'(eols), 32'(frames * 2 * H));
        chk({name, "_fifo_reads"}, 32'(rds), 32'(frames * W * H));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst     = 1'b1;
        m_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_flags", {29'd0, m_sof, m_eol, frame_done}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential pixels, continuous feed, always ready.
        clear_stats();
        push_frame(1'b1);
        wait_frames(1, "seq_frame");
        check_stats("seq_frame", 1);

        // Starved FIFO: count toggles between 1 and 0 every 3 cycles.
        clear_stats();
        starve = 1;
        push_frame(1'b0);
        wait_frames(2, "starve_frame");
        check_stats("starve_frame", 1);
        starve = 0;

        // Random backpressure.
        clear_stats();
        bp_mode = 1;
        push_frame(1'b0);
        wait_frames(3, "bp_frame");
        check_stats("bp_frame", 1);
        bp_mode = 0;

        // Reset in the middle of EMIT.
        clear_stats();
        push_frame(1'b1);
        n = 0;
        while (beats < 10 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("reach_beat10", 32'(beats >= 10), 32'd1);
        #1 rst = 1'b1;
        fq.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fifo_rd", 32'(fifo_rd), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_stats();
        push_frame(1'b1);
        wait_frames(4, "post_rst_frame");
        check_stats("post_rst_frame", 1);

        // Two frames queued back to back.
        clear_stats();
        push_frame(1'b0);
        push_frame(1'b0);
        wait_frames(6, "b2b_frames");
        check_stats("b2b_frames", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
